// File: rtl/bin_to_sseg3_pkg.sv
// rtl/bin_to_sseg3_pkg.sv - shared segment constants, FSM states and BCD helper
package bin_to_sseg3_pkg;

  // Bit positions inside a pattern {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-low digit patterns with the decimal point dark
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int BIN_W    = 8;
  localparam int SHREG_W  = 20;
  localparam logic [3:0] LAST_SHIFT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ENCODE
  } state_t;

  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin_to_sseg3_bcd_to_sseg.sv
// rtl/bin_to_sseg3_bcd_to_sseg.sv - one BCD digit plus blank/dp to a segment pattern
module bcd_to_sseg
  import bin_to_sseg3_pkg::*;
#(
  parameter bit SEG_ALOW = 1'b1
) (
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] w_pat;

  always_comb begin
    w_pat = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    w_pat = SEG_0;
        4'd1:    w_pat = SEG_1;
        4'd2:    w_pat = SEG_2;
        4'd3:    w_pat = SEG_3;
        4'd4:    w_pat = SEG_4;
        4'd5:    w_pat = SEG_5;
        4'd6:    w_pat = SEG_6;
        4'd7:    w_pat = SEG_7;
        4'd8:    w_pat = SEG_8;
        4'd9:    w_pat = SEG_9;
        default: w_pat = SEG_BLANK;
      endcase
    end
    // The decimal point stays independent of blanking
    w_pat[SEG_DP] = ~i_dp;
    o_seg = SEG_ALOW ? w_pat : ~w_pat;
  end

endmodule

// File: rtl/bin_to_sseg3.sv
// rtl/bin_to_sseg3.sv - 8-bit binary to three seven-segment digits via serial double-dabble
module bin_to_sseg3
  import bin_to_sseg3_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1,
  parameter bit SEG_ALOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  input  logic [2:0]       dp,
  output logic             busy,
  output logic             done,
  output logic [7:0]       seg2,
  output logic [7:0]       seg1,
  output logic [7:0]       seg0
);

  localparam logic [7:0] SEG_RESET = SEG_ALOW ? SEG_BLANK : ~SEG_BLANK;

  state_t             r_state;
  state_t             w_next;
  logic [SHREG_W-1:0] r_shreg;
  logic [3:0]         r_cnt;
  logic [2:0]         r_dp;
  logic               r_done;
  logic [7:0]         r_seg2;
  logic [7:0]         r_seg1;
  logic [7:0]         r_seg0;

  logic [3:0] w_h;
  logic [3:0] w_t;
  logic [3:0] w_u;
  logic       w_blank2;
  logic       w_blank1;
  logic [7:0] w_seg2;
  logic [7:0] w_seg1;
  logic [7:0] w_seg0;

  assign w_h      = r_shreg[19:16];
  assign w_t      = r_shreg[15:12];
  assign w_u      = r_shreg[11:8];
  assign w_blank2 = BLANK_LZ && (w_h == 4'd0);
  assign w_blank1 = BLANK_LZ && (w_h == 4'd0) && (w_t == 4'd0);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_SHIFT;
      ST_SHIFT:  if (r_cnt == LAST_SHIFT) w_next = ST_ENCODE;
      ST_ENCODE: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shreg <= '0;
      r_cnt   <= 4'd0;
      r_dp    <= 3'd0;
      r_done  <= 1'b0;
      r_seg2  <= SEG_RESET;
      r_seg1  <= SEG_RESET;
      r_seg0  <= SEG_RESET;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shreg <= {12'b0, bin};
            r_dp    <= dp;
            r_cnt   <= 4'd0;
          end
        end
        ST_SHIFT: begin
          // Correct every BCD nibble first, then shift the whole register
          r_shreg <= {dabble_adj(w_h), dabble_adj(w_t), dabble_adj(w_u),
                      r_shreg[7:0]} << 1;
          r_cnt   <= r_cnt + 4'd1;
        end
        ST_ENCODE: begin
          r_seg2 <= w_seg2;
          r_seg1 <= w_seg1;
          r_seg0 <= w_seg0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  bcd_to_sseg #(.SEG_ALOW(SEG_ALOW)) u_dig2 (
    .i_digit (w_h),
    .i_blank (w_blank2),
    .i_dp    (r_dp[2]),
    .o_seg   (w_seg2)
  );

  bcd_to_sseg #(.SEG_ALOW(SEG_ALOW)) u_dig1 (
    .i_digit (w_t),
    .i_blank (w_blank1),
    .i_dp    (r_dp[1]),
    .o_seg   (w_seg1)
  );

  bcd_to_sseg #(.SEG_ALOW(SEG_ALOW)) u_dig0 (
    .i_digit (w_u),
    .i_blank (1'b0),
    .i_dp    (r_dp[0]),
    .o_seg   (w_seg0)
  );

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign seg2 = r_seg2;
  assign seg1 = r_seg1;
  assign seg0 = r_seg0;

endmodule

// File: tb/tb_bin_to_sseg3.sv
// tb/tb_bin_to_sseg3.sv - directed and exhaustive bench for bin_to_sseg3
module tb_bin_to_sseg3;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] bin;
  logic [2:0] dp;

  logic       busy, done;
  logic [7:0] seg2, seg1, seg0;
  logic       busy_nb, done_nb;
  logic [7:0] seg2_nb, seg1_nb, seg0_nb;
  logic       busy_inv, done_inv;
  logic [7:0] seg2_inv, seg1_inv, seg0_inv;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0]  DIR_BIN [6] = '{8'd255, 8'd100, 8'd9, 8'd70, 8'd5, 8'd200};
  localparam logic [2:0]  DIR_DP  [6] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b111, 3'b100};
  localparam logic [23:0] DIR_EXP [6] = '{24'hA49292, 24'hF9C0C0, 24'hFFFF90,
                                          24'hFF78C0, 24'h7F7F12, 24'h24C0C0};

  always #5 clk = ~clk;

  bin_to_sseg3 u_dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin), .dp(dp),
    .busy(busy), .done(done), .seg2(seg2), .seg1(seg1), .seg0(seg0)
  );

  bin_to_sseg3 #(.BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .reset(reset), .start(start), .bin(bin), .dp(dp),
    .busy(busy_nb), .done(done_nb), .seg2(seg2_nb), .seg1(seg1_nb), .seg0(seg0_nb)
  );

  bin_to_sseg3 #(.SEG_ALOW(1'b0)) u_dut_inv (
    .clk(clk), .reset(reset), .start(start), .bin(bin), .dp(dp),
    .busy(busy_inv), .done(done_inv), .seg2(seg2_inv), .seg1(seg1_inv), .seg0(seg0_inv)
  );

  function automatic logic [7:0] model_digit(input int d, input bit blank, input bit dpb, input bit alow);
    logic [7:0] p;
    case (d)
      0: p = 8'hC0;  1: p = 8'hF9;  2: p = 8'hA4;  3: p = 8'hB0;  4: p = 8'h99;
      5: p = 8'h92;  6: p = 8'h82;  7: p = 8'hF8;  8: p = 8'h80;  9: p = 8'h90;
      default: p = 8'hFF;
    endcase
    if (blank) p = 8'hFF;
    p[7] = ~dpb;
    return alow ? p : ~p;
  endfunction

  function automatic logic [23:0] model3(input int v, input logic [2:0] d, input bit blz, input bit alow);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    return {model_digit(h, blz && (h == 0), d[2], alow),
            model_digit(t, blz && (h == 0) && (t == 0), d[1], alow),
            model_digit(u, 1'b0, d[0], alow)};
  endfunction

  // Returns #1 after the accepting edge; bin/dp are then scrambled
  task automatic start_conv(input logic [7:0] b, input logic [2:0] d);
    @(negedge clk);
    bin = b; dp = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; bin = ~b; dp = ~d;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; bin = 8'd0; dp = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, busy_nb, done_nb, busy_inv, done_inv} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000", {busy, done, busy_nb, done_nb, busy_inv, done_inv});
    end
    checks++;
    if ({seg2, seg1, seg0} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL reset_segs: got %h expected ffffff", {seg2, seg1, seg0});
    end
    checks++;
    if ({seg2_inv, seg1_inv, seg0_inv} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_segs_inv: got %h expected 000000", {seg2_inv, seg1_inv, seg0_inv});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_zero;
    int lat;
    start_conv(8'd0, 3'b000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy_after_accept: got %b expected 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 9", lat);
    end
    checks++;
    if ({seg2, seg1, seg0, busy} !== {24'hFFFFC0, 1'b0}) begin
      errors++;
      $display("FAIL zero_segs_busy: got %h/%b expected ffffc0/0", {seg2, seg1, seg0}, busy);
    end
    checks++;
    if ({seg2_nb, seg1_nb, seg0_nb} !== 24'hC0C0C0) begin
      errors++;
      $display("FAIL zero_noblank: got %h expected c0c0c0", {seg2_nb, seg1_nb, seg0_nb});
    end
    checks++;
    if ({seg2_inv, seg1_inv, seg0_inv} !== 24'h00003F) begin
      errors++;
      $display("FAIL zero_inverted: got %h expected 00003f", {seg2_inv, seg1_inv, seg0_inv});
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_width: got %b expected 0", done);
    end
  endtask

  task automatic test_directed;
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_conv(DIR_BIN[i], DIR_DP[i]);
      wait_done(lat);
      checks++;
      if (lat !== 9 || {seg2, seg1, seg0} !== DIR_EXP[i]) begin
        errors++;
        $display("FAIL directed_bin%0d: got %h lat %0d expected %h lat 9",
                 DIR_BIN[i], {seg2, seg1, seg0}, lat, DIR_EXP[i]);
      end
      if (i == 0) begin
        checks++;
        if ({seg2_inv, seg1_inv, seg0_inv} !== 24'h5B6D6D) begin
          errors++;
          $display("FAIL directed_inv255: got %h expected 5b6d6d", {seg2_inv, seg1_inv, seg0_inv});
        end
      end
    end
  endtask

  task automatic test_no_blank;
    int lat;
    start_conv(8'd7, 3'b000);
    wait_done(lat);
    checks++;
    if (lat !== 9 || {seg2_nb, seg1_nb, seg0_nb} !== 24'hC0C0F8) begin
      errors++;
      $display("FAIL noblank_7: got %h lat %0d expected c0c0f8 lat 9", {seg2_nb, seg1_nb, seg0_nb}, lat);
    end
  endtask

  task automatic test_ignore_busy;
    int first, n_done;
    first = -1;
    n_done = 0;
    start_conv(8'd123, 3'b000);
    repeat (2) @(posedge clk);
    // Hold a competing request from E+3 through the ENCODE->IDLE edge
    @(negedge clk);
    start = 1'b1; bin = 8'd200; dp = 3'b111;
    for (int k = 3; k <= 9; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_done++;
        if (first < 0) first = k;
      end
    end
    start = 1'b0;
    for (int k = 10; k <= 22; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    checks++;
    if (first !== 9 || n_done !== 1) begin
      errors++;
      $display("FAIL ignore_done: got first %0d count %0d expected first 9 count 1", first, n_done);
    end
    checks++;
    if ({seg2, seg1, seg0, busy} !== {24'hF9A4B0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_segs: got %h/%b expected f9a4b0/0", {seg2, seg1, seg0}, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_conv(8'd42, 3'b000);
    wait_done(lat);
    checks++;
    if (lat !== 9 || {seg2, seg1, seg0} !== 24'hFF99A4) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d expected ff99a4 lat 9", {seg2, seg1, seg0}, lat);
    end
    start_conv(8'd158, 3'b001);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy %b expected 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 9 || {seg2, seg1, seg0} !== 24'hF99200) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d expected f99200 lat 9", {seg2, seg1, seg0}, lat);
    end
  endtask

  task automatic test_reset_mid;
    int n_done;
    n_done = 0;
    start_conv(8'd88, 3'b000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, seg2, seg1, seg0} !== {2'b00, 24'hFFFFFF}) begin
      errors++;
      $display("FAIL resetmid_state: got %b%b %h expected 00 ffffff", busy, done, {seg2, seg1, seg0});
    end
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) n_done++;
    end
    checks++;
    if (n_done !== 0 || {seg2, seg1, seg0} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL resetmid_after: got activity %0d segs %h expected 0 ffffff", n_done, {seg2, seg1, seg0});
    end
  endtask

  task automatic test_exhaustive;
    int lat;
    logic [7:0]  vb;
    logic [2:0]  vd;
    logic [23:0] e, e_nb, e_inv;
    for (int v = 0; v < 256; v++) begin
      vb = v[7:0];
      vd = vb[2:0] ^ vb[5:3];
      e     = model3(v, vd, 1'b1, 1'b1);
      e_nb  = model3(v, vd, 1'b0, 1'b1);
      e_inv = model3(v, vd, 1'b1, 1'b0);
      start_conv(vb, vd);
      wait_done(lat);
      checks++;
      if (lat !== 9 || {seg2, seg1, seg0} !== e || {seg2_nb, seg1_nb, seg0_nb} !== e_nb ||
          {seg2_inv, seg1_inv, seg0_inv} !== e_inv) begin
        errors++;
        $display("FAIL exhaustive_%0d: got %h/%h/%h lat %0d expected %h/%h/%h lat 9", v,
                 {seg2, seg1, seg0}, {seg2_nb, seg1_nb, seg0_nb}, {seg2_inv, seg1_inv, seg0_inv},
                 lat, e, e_nb, e_inv);
      end
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_directed;
    test_no_blank;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    test_exhaustive;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
